// File: rtl/fifo_rd_stream.sv
// FIFO read-port consumer: issues reads when space allows, re-times the read data into a
// 2-entry buffer and presents it as a valid/ready stream. Define FIFO_RD_CNT_EN for word_cnt.
module fifo_rd_stream #(
   parameter int DATA_W = 16
`ifdef FIFO_RD_CNT_EN
  ,parameter int CNT_W  = 32
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic              fifo_ren,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
`ifdef FIFO_RD_CNT_EN
  ,output logic [CNT_W-1:0]  word_cnt
`endif
);

   logic [1:0]        count_r;
   logic              inflight_r;
   logic              valid_r;
   logic [DATA_W-1:0] head_r;
   logic [DATA_W-1:0] tail_r;

   logic              pop_s;
   logic [1:0]        occ_s;
   logic [1:0]        count_next_s;
   logic [1:0]        slot_s;
   logic [DATA_W-1:0] head_next_s;
   logic [DATA_W-1:0] tail_next_s;

   // Pop, occupancy and the read-enable decision.
   always_comb begin
      pop_s        = valid_r & out_ready;
      occ_s        = count_r + {1'b0, inflight_r};
      count_next_s = occ_s - {1'b0, pop_s};
      fifo_ren     = rst_n & ~fifo_empty & ~flush & ((occ_s < 2'd2) | pop_s);
   end

   // Next buffer contents: shift on pop, then land the in-flight word after the tail.
   always_comb begin
      head_next_s = pop_s ? tail_r : head_r;
      tail_next_s = tail_r;
      slot_s      = count_r - {1'b0, pop_s};
      if (inflight_r) begin
         case (slot_s)
            2'd0:    head_next_s = fifo_dout;
            2'd1:    tail_next_s = fifo_dout;
            default: tail_next_s = tail_r;
         endcase
      end else begin
         tail_next_s = tail_r;
      end
   end

   // Buffer state; flush drops buffered words and the word arriving this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r    <= 2'd0;
         inflight_r <= 1'b0;
         valid_r    <= 1'b0;
         head_r     <= {DATA_W{1'b0}};
         tail_r     <= {DATA_W{1'b0}};
      end else if (flush) begin
         count_r    <= 2'd0;
         inflight_r <= 1'b0;
         valid_r    <= 1'b0;
      end else begin
         count_r    <= count_next_s;
         inflight_r <= fifo_ren;
         valid_r    <= (count_next_s != 2'd0);
         head_r     <= head_next_s;
         tail_r     <= tail_next_s;
      end
   end

   assign out_data  = head_r;
   assign out_valid = valid_r;

`ifdef FIFO_RD_CNT_EN
   logic [CNT_W-1:0] word_cnt_r;

   // Delivered-word counter; survives flush, wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt_r <= {CNT_W{1'b0}};
      end else if (pop_s) begin
         word_cnt_r <= word_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign word_cnt = word_cnt_r;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed self-checking bench for fifo_rd_stream with a behavioural 1-cycle-latency FIFO.
module tb_fifo_rd_stream;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        fifo_empty;
   logic [15:0] fifo_dout;
   logic        fifo_ren;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
`ifdef FIFO_RD_CNT_EN
   logic [31:0] word_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   logic [15:0] mem [0:63];
   int          rd_ptr = 0;
   int          wr_ptr = 0;

   fifo_rd_stream dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_ren   (fifo_ren),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
`ifdef FIFO_RD_CNT_EN
     ,.word_cnt   (word_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (fifo_ren) begin
         fifo_dout <= mem[rd_ptr];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   task automatic push(input logic [15:0] w);
      mem[wr_ptr] = w;
      wr_ptr      = wr_ptr + 1;
   endtask

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      fifo_dout = 16'h0000;
      push(16'hA5A5);
      next_cycle();
      next_cycle();
      checks++;
      if (fifo_ren !== 1'b0) begin failures++; $display("FAIL reset_ren got=%b exp=0", fifo_ren); end
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++;
      if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", out_data); end
`ifdef FIFO_RD_CNT_EN
      checks++;
      if (word_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", word_cnt); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (fifo_ren !== 1'b1) begin failures++; $display("FAIL release_ren got=%b exp=1", fifo_ren); end
   endtask

   task automatic test_latency();
      next_cycle();
      checks++;
      if (out_valid !== 1'b0 || fifo_ren !== 1'b0) begin
         failures++; $display("FAIL lat_t1 valid=%b ren=%b exp valid=0 ren=0", out_valid, fifo_ren);
      end
      next_cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'hA5A5) begin
         failures++; $display("FAIL lat_t2 valid=%b data=%h exp valid=1 data=a5a5", out_valid, out_data);
      end
      next_cycle();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_t3 valid=%b exp=0", out_valid); end
   endtask

   task automatic test_streaming();
      int got = 0;
      int gaps = 0;
      int ren_cnt = 0;
      for (int i = 1; i <= 8; i++) push(16'(i));
      #1;
      for (int c = 0; c < 20; c++) begin
         if (c < 8 && fifo_ren === 1'b1) ren_cnt++;
         if (out_valid === 1'b1) begin
            if (got < 8) begin
               checks++;
               if (out_data !== 16'(got + 1)) begin
                  failures++; $display("FAIL stream_data idx=%0d got=%h exp=%h", got, out_data, 16'(got + 1));
               end
            end
            got++;
         end else if (got > 0 && got < 8) begin
            gaps++;
         end
         next_cycle();
      end
      checks++;
      if (got !== 8) begin failures++; $display("FAIL stream_count got=%0d exp=8", got); end
      checks++;
      if (gaps !== 0) begin failures++; $display("FAIL stream_gaps got=%0d exp=0", gaps); end
      checks++;
      if (ren_cnt !== 8) begin failures++; $display("FAIL stream_ren got=%0d exp=8", ren_cnt); end
   endtask

   task automatic test_backpressure();
      logic [4:0] exp_ren;
      int got = 0;
      exp_ren   = 5'b00011;
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) push(16'h0010 + 16'(i));
      #1;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (fifo_ren !== exp_ren[c]) begin
            failures++; $display("FAIL bp_ren cyc=%0d got=%b exp=%b", c, fifo_ren, exp_ren[c]);
         end
         if (c >= 2) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h0010) begin
               failures++; $display("FAIL bp_hold cyc=%0d valid=%b data=%h exp valid=1 data=0010", c, out_valid, out_data);
            end
         end
         next_cycle();
      end
      out_ready = 1'b1;
      #1;
      for (int c = 0; c < 20; c++) begin
         if (out_valid === 1'b1) begin
            if (got < 6) begin
               checks++;
               if (out_data !== 16'h0010 + 16'(got)) begin
                  failures++; $display("FAIL bp_data idx=%0d got=%h exp=%h", got, out_data, 16'h0010 + 16'(got));
               end
            end
            got++;
         end
         next_cycle();
      end
      checks++;
      if (got !== 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", got); end
   endtask

   task automatic test_flush();
      int got = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) push(16'h0031 + 16'(i));
      #1;
      next_cycle();
      next_cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0031) begin
         failures++; $display("FAIL fl_pre valid=%b data=%h exp valid=1 data=0031", out_valid, out_data);
      end
      flush = 1'b1;
      #1;
      checks++;
      if (fifo_ren !== 1'b0) begin failures++; $display("FAIL fl_ren got=%b exp=0", fifo_ren); end
      next_cycle();
      flush = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || fifo_ren !== 1'b1) begin
         failures++; $display("FAIL fl_post valid=%b ren=%b exp valid=0 ren=1", out_valid, fifo_ren);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (out_valid === 1'b1) begin
            if (got < 4) begin
               checks++;
               if (out_data !== 16'h0033 + 16'(got)) begin
                  failures++; $display("FAIL fl_data idx=%0d got=%h exp=%h", got, out_data, 16'h0033 + 16'(got));
               end
            end
            got++;
         end
         next_cycle();
      end
      checks++;
      if (got !== 4) begin failures++; $display("FAIL fl_count got=%0d exp=4", got); end
   endtask

   task automatic test_empty_gap();
      logic [4:0]  exp_ren;
      logic [4:0]  exp_vld;
      logic [15:0] exp_dat [0:4];
      exp_ren = 5'b00011;
      exp_vld = 5'b01100;
      exp_dat[0] = 16'h0000; exp_dat[1] = 16'h0000; exp_dat[2] = 16'h0041;
      exp_dat[3] = 16'h0042; exp_dat[4] = 16'h0000;
      out_ready = 1'b1;
      push(16'h0041);
      push(16'h0042);
      #1;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (fifo_ren !== exp_ren[c] || out_valid !== exp_vld[c] ||
             (exp_vld[c] && out_data !== exp_dat[c])) begin
            failures++;
            $display("FAIL empty_gap cyc=%0d ren=%b valid=%b data=%h exp ren=%b valid=%b data=%h",
                     c, fifo_ren, out_valid, out_data, exp_ren[c], exp_vld[c], exp_dat[c]);
         end
         next_cycle();
      end
   endtask

`ifdef FIFO_RD_CNT_EN
   task automatic test_word_cnt();
      rst_n = 1'b0;
      #1;
      checks++;
      if (word_cnt !== 32'd0) begin failures++; $display("FAIL cnt_rst got=%0d exp=0", word_cnt); end
      next_cycle();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) push(16'h0051 + 16'(i));
      for (int c = 0; c < 12; c++) next_cycle();
      checks++;
      if (word_cnt !== 32'd5) begin failures++; $display("FAIL cnt_first got=%0d exp=5", word_cnt); end
      flush = 1'b1;
      next_cycle();
      flush = 1'b0;
      #1;
      checks++;
      if (word_cnt !== 32'd5) begin failures++; $display("FAIL cnt_flush got=%0d exp=5", word_cnt); end
      for (int i = 0; i < 3; i++) push(16'h0056 + 16'(i));
      for (int c = 0; c < 10; c++) next_cycle();
      checks++;
      if (word_cnt !== 32'd8) begin failures++; $display("FAIL cnt_total got=%0d exp=8", word_cnt); end
      out_ready = 1'b0;
      push(16'h0061);
      for (int c = 0; c < 4; c++) next_cycle();
      force dut.word_cnt_r = 32'hFFFF_FFFF;
      #1;
      release dut.word_cnt_r;
      #1;
      checks++;
      if (word_cnt !== 32'hFFFF_FFFF || out_valid !== 1'b1) begin
         failures++; $display("FAIL cnt_preload cnt=%h valid=%b exp cnt=ffffffff valid=1", word_cnt, out_valid);
      end
      out_ready = 1'b1;
      next_cycle();
      checks++;
      if (word_cnt !== 32'd0) begin failures++; $display("FAIL cnt_wrap got=%h exp=00000000", word_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_latency();
      test_streaming();
      test_backpressure();
      test_flush();
      test_empty_gap();
`ifdef FIFO_RD_CNT_EN
      test_word_cnt();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
